// File: rtl/instr_encoder.sv
// Streaming RV32I I-format encoder (OP-IMM, LW, JALR) with immediate range checks,
// a 2-entry output FIFO under valid/ready flow control, and encode/error counters.
module instr_encoder #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [2:0]       in_funct3,
  input  logic             in_srai,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_FW  = 2;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [2:0]  F3_LW      = 3'b010;
  localparam logic [2:0]  F3_JALR    = 3'b000;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013;
  localparam logic [CNT_FW-1:0]  FIFO_FULL = 2'd2;

  // Combinational encoder for the word offered on the input this cycle
  logic [6:0]         w_opcode;
  logic [2:0]         w_f3;
  logic               w_is_shift;
  logic [11:0]        w_imm12;
  logic               w_imm_err;
  logic [INSTR_W-1:0] w_instr;
  logic               w_err;

  always_comb begin
    w_opcode   = OPC_OP_IMM;
    w_f3       = in_funct3;
    w_is_shift = 1'b0;
    w_imm12    = in_imm[11:0];
    w_imm_err  = 1'b0;
    w_instr    = NOP_WORD;
    w_err      = 1'b0;

    case (in_op)
      2'b00: begin
        w_opcode   = OPC_OP_IMM;
        w_f3       = in_funct3;
        w_is_shift = (in_funct3[1:0] == 2'b01);
      end
      2'b01: begin
        w_opcode = OPC_LOAD;
        w_f3     = F3_LW;
      end
      2'b10: begin
        w_opcode = OPC_JALR;
        w_f3     = F3_JALR;
      end
      default: begin
        w_opcode = OPC_OP_IMM;
        w_f3     = 3'b000;
      end
    endcase

    // Shifts carry a 5-bit shamt; bit 10 selects arithmetic right shift
    if (w_is_shift) begin
      w_imm12   = {1'b0, in_srai & in_funct3[2], 5'b00000, in_imm[4:0]};
      w_imm_err = |in_imm[31:5];
    end else begin
      w_imm12   = in_imm[11:0];
      w_imm_err = ~((&in_imm[31:11]) | ~(|in_imm[31:11]));
    end

    if (in_op == 2'b11) begin
      w_instr = NOP_WORD;
      w_err   = 1'b1;
    end else begin
      w_instr = {w_imm12, in_rs1, w_f3, in_rd, w_opcode};
      w_err   = w_imm_err;
    end
  end

  // FIFO state: head slot drives the outputs directly, tail holds the second word
  logic [CNT_FW-1:0]  r_count;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [INSTR_W-1:0] r_head_instr;
  logic               r_head_err;
  logic [INSTR_W-1:0] r_tail_instr;
  logic               r_tail_err;
  logic [CNT_W-1:0]   r_enc_count;
  logic [ERR_W-1:0]   r_err_count;

  logic              w_push;
  logic              w_pop;
  logic [CNT_FW-1:0] w_count_nxt;

  always_comb begin
    w_push      = in_valid & r_in_ready;
    w_pop       = r_out_valid & out_ready;
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_FW'(1);
      2'b01:   w_count_nxt = r_count - CNT_FW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // in_ready/out_valid are registered from the next count, so a pop from full
  // only reopens the input on the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_head_instr <= '0;
      r_head_err   <= 1'b0;
      r_tail_instr <= '0;
      r_tail_err   <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt < FIFO_FULL);
      r_out_valid <= (w_count_nxt != '0);

      if (w_pop && (r_count == FIFO_FULL)) begin
        r_head_instr <= r_tail_instr;
        r_head_err   <= r_tail_err;
      end

      if (w_push) begin
        if ((r_count == '0) || ((r_count == CNT_FW'(1)) && w_pop)) begin
          r_head_instr <= w_instr;
          r_head_err   <= w_err;
        end else begin
          r_tail_instr <= w_instr;
          r_tail_err   <= w_err;
        end
      end
    end
  end

  // Output-handshake counter wraps; error counter saturates at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enc_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_pop) begin
        r_enc_count <= r_enc_count + CNT_W'(1);
      end
      if (w_push && w_err && (r_err_count != '1)) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_instr = r_head_instr;
  assign out_err   = r_head_err;
  assign enc_count = r_enc_count;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words queued on input accept,
// compared in order when the encoder hands them out.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [2:0]  in_funct3;
  logic        in_srai;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  instr_encoder #(.CNT_W(16), .ERR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_funct3 (in_funct3),
    .in_srai   (in_srai),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoding, written from the ISA field layout
  function automatic logic [32:0] model(input logic [1:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic srai, input logic [31:0] imm);
    logic [6:0]  opc;
    logic [2:0]  f;
    logic [11:0] i12;
    logic        e;
    if (op == 2'b11) return {1'b1, 32'h0000_0013};
    opc = (op == 2'b00) ? 7'h13 : (op == 2'b01) ? 7'h03 : 7'h67;
    f   = (op == 2'b00) ? f3 : (op == 2'b01) ? 3'd2 : 3'd0;
    if (op == 2'b00 && (f == 3'd1 || f == 3'd5)) begin
      i12 = 12'(imm[4:0]);
      if (srai && f == 3'd5) i12 = i12 | 12'h400;
      e = (imm > 32'd31);
    end else begin
      i12 = imm[11:0];
      e = ($signed(imm) < -2048) || ($signed(imm) > 2047);
    end
    return {e, i12, rs1, f, rd, opc};
  endfunction

  // Offer one word; must be called just after a rising edge
  task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [2:0] f3, input logic srai, input logic [31:0] imm,
                      input logic [31:0] ei, input logic ee);
    int n = 0;
    bit ok = 0;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_funct3 = f3; in_srai = srai; in_imm = imm;
    in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back({ee, ei});
        ok = 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
  endtask

  // Output monitor: in-order compare on handshake, stability check while stalled
  bit          prev_stall = 0;
  logic [31:0] prev_instr;
  logic        prev_err;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_instr", out_instr, prev_instr);
        chk("hold_err", 32'(out_err), 32'(prev_err));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_word", out_instr, 32'hxxxx_xxxx);
        end else begin
          logic [32:0] e;
          e = sb_q.pop_front();
          chk("instr", out_instr, e[31:0]);
          chk("err", 32'(out_err), 32'(e[32]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_err   = out_err;
    end
  end

  bit rdone;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_rd = '0; in_rs1 = '0;
    in_funct3 = '0; in_srai = 1'b0; in_imm = '0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_enc", 32'(enc_count), 32'd0);
    chk("rst_errc", 32'(err_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // ADDI, first-word latency
    send(2'b00, 5'd1, 5'd2, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    wait_drain();

    // LW (funct3 ignored), JALR
    send(2'b01, 5'd5, 5'd10, 3'b111, 1'b0, 32'd8, 32'h0085_2283, 1'b0);
    send(2'b10, 5'd0, 5'd1, 3'b000, 1'b0, 32'd0, 32'h0000_8067, 1'b0);
    wait_drain();
    chk("enc_after_t2", 32'(enc_count), 32'd3);

    // Out-of-range immediate and reserved op
    send(2'b00, 5'd1, 5'd2, 3'b000, 1'b0, 32'd2048, 32'h8001_0093, 1'b1);
    wait_drain();
    chk("errc_1", 32'(err_count), 32'd1);
    send(2'b11, 5'd7, 5'd7, 3'b000, 1'b0, 32'd0, 32'h0000_0013, 1'b1);
    wait_drain();
    chk("errc_2", 32'(err_count), 32'd2);

    // SRAI legal and out-of-range shamt
    send(2'b00, 5'd3, 5'd3, 3'b101, 1'b1, 32'd4, 32'h4041_D193, 1'b0);
    send(2'b00, 5'd3, 5'd3, 3'b101, 1'b1, 32'd32, 32'h4001_D193, 1'b1);
    wait_drain();
    chk("errc_3", 32'(err_count), 32'd3);

    // Backpressure: fill, stall, then release
    out_ready = 1'b0;
    send(2'b00, 5'd4, 5'd0, 3'b000, 1'b0, 32'd100, 32'h0640_0213, 1'b0);
    send(2'b00, 5'd5, 5'd4, 3'b111, 1'b0, 32'hFFFF_FFF0, 32'hFF02_7293, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head", out_instr, 32'h0640_0213);
    fork
      send(2'b10, 5'd1, 5'd5, 3'b000, 1'b0, 32'hFFFF_FFFC, 32'hFFC2_80E7, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("stall_head", out_instr, 32'h0640_0213);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("reopen_in_ready", 32'(in_ready), 32'd1);
      end
    join
    wait_drain();
    chk("enc_after_t5", 32'(enc_count), 32'd10);

    // Random stream with random backpressure
    rdone = 0;
    fork
      begin
        for (int k = 0; k < 48; k++) begin
          logic [1:0]  op;
          logic [2:0]  f3;
          logic [31:0] imm;
          logic [4:0]  rd, rs1;
          logic        sr;
          logic [32:0] e;
          op  = 2'($urandom_range(0, 3));
          f3  = 3'($urandom_range(0, 7));
          rd  = 5'($urandom);
          rs1 = 5'($urandom);
          sr  = 1'($urandom);
          case ($urandom_range(0, 2))
            0:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            1:       imm = 32'($urandom_range(0, 40));
            default: imm = $urandom;
          endcase
          e = model(op, rd, rs1, f3, sr, imm);
          send(op, rd, rs1, f3, sr, imm, e[31:0], e[32]);
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("enc_after_rand", 32'(enc_count), 32'd58);

    // Error counter saturation
    for (int k = 0; k < 260; k++)
      send(2'b11, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0, 32'h0000_0013, 1'b1);
    wait_drain();
    chk("errc_sat", 32'(err_count), 32'd255);
    chk("enc_after_sat", 32'(enc_count), 32'd318);

    // Asynchronous reset with two words buffered
    out_ready = 1'b0;
    send(2'b00, 5'd1, 5'd1, 3'b000, 1'b0, 32'd1, 32'h0010_8093, 1'b0);
    send(2'b00, 5'd2, 5'd2, 3'b000, 1'b0, 32'd2, 32'h0021_0113, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_enc", 32'(enc_count), 32'd0);
    chk("arst_errc", 32'(err_count), 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arel_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("no_stale", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    send(2'b00, 5'd1, 5'd2, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
    wait_drain();
    chk("enc_after_arst", 32'(enc_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
